// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF measurement sequencer: enables one challenge pair, counts
// synchronised rising edges of each ring over a fixed window, compares the counts.
module ro_puf_controller #(
  parameter int NUM_RO        = 16,
  parameter int SEL_W         = 4,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int WINDOW        = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SEL_W-1:0]  Sel_A,
  input  logic [SEL_W-1:0]  Sel_B,
  input  logic [NUM_RO-1:0] RO_in,
  output logic [NUM_RO-1:0] RO_enable,
  output logic              Busy,
  output logic              Done,
  output logic              Response,
  output logic              Tie,
  output logic              Error,
  output logic [CNT_W-1:0]  Count_A,
  output logic [CNT_W-1:0]  Count_B
);

  localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel_a;
  logic [SEL_W-1:0] r_sel_b;
  logic [TMR_W-1:0] r_tmr;
  logic             w_accept;
  logic             w_legal;
  logic             w_settle_end;
  logic             w_count_end;
  logic             w_ro_a;
  logic             w_ro_b;
  logic [2:0]       r_sync_a;
  logic [2:0]       r_sync_b;
  logic             w_rise_a;
  logic             w_rise_b;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic             r_resp;
  logic             r_tie;
  logic             r_err;

  assign w_accept     = (r_state == S_IDLE) && Start;
  assign w_legal      = (Sel_A != Sel_B) && (int'(Sel_A) < NUM_RO) && (int'(Sel_B) < NUM_RO);
  assign w_settle_end = (r_tmr == TMR_W'(SETTLE_CYCLES - 1));
  assign w_count_end  = (r_tmr == TMR_W'(WINDOW - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (Start) w_next = w_legal ? S_SETTLE : S_DONE;
      S_SETTLE:  if (w_settle_end) w_next = S_COUNT;
      S_COUNT:   if (w_count_end) w_next = S_COMPARE;
      S_COMPARE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Enables are decoded from the state register so reset removes them without a clock.
  always_comb begin
    RO_enable = '0;
    Busy      = (r_state != S_IDLE);
    Done      = (r_state == S_DONE);
    if (r_state == S_SETTLE || r_state == S_COUNT) begin
      for (int i = 0; i < NUM_RO; i++) begin
        RO_enable[i] = (r_sel_a == SEL_W'(i)) || (r_sel_b == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (w_accept) begin
      r_sel_a <= Sel_A;
      r_sel_b <= Sel_B;
    end
  end

  // One timer serves both phases; it restarts at every phase boundary.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tmr <= '0;
    end else if ((r_state == S_SETTLE && !w_settle_end) ||
                 (r_state == S_COUNT && !w_count_end)) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end else begin
      r_tmr <= '0;
    end
  end

  always_comb begin
    w_ro_a = 1'b0;
    w_ro_b = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (r_sel_a == SEL_W'(i)) w_ro_a = RO_in[i];
      if (r_sel_b == SEL_W'(i)) w_ro_b = RO_in[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[1:0], w_ro_a};
      r_sync_b <= {r_sync_b[1:0], w_ro_b};
    end
  end

  assign w_rise_a = r_sync_a[1] & ~r_sync_a[2];
  assign w_rise_b = r_sync_b[1] & ~r_sync_b[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_accept) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_COUNT) begin
      if (w_rise_a && (r_cnt_a != {CNT_W{1'b1}})) r_cnt_a <= r_cnt_a + CNT_W'(1);
      if (w_rise_b && (r_cnt_b != {CNT_W{1'b1}})) r_cnt_b <= r_cnt_b + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_resp <= 1'b0;
      r_tie  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp <= 1'b0;
      r_tie  <= 1'b0;
      r_err  <= ~w_legal;
    end else if (r_state == S_COMPARE) begin
      r_resp <= (r_cnt_a > r_cnt_b);
      r_tie  <= (r_cnt_a == r_cnt_b);
    end
  end

  assign Response = r_resp;
  assign Tie      = r_tie;
  assign Error    = r_err;
  assign Count_A  = r_cnt_a;
  assign Count_B  = r_cnt_b;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: behavioural ring models, a vector table,
// randomized challenges against an arithmetic expectation, and corner sequences.
`timescale 1ns/1ps
module tb_ro_puf_controller;

  localparam int NUM_RO    = 16;
  localparam int SEL_W     = 5;
  localparam int CNT_W     = 16;
  localparam int SET_C     = 8;
  localparam int WIN       = 240;
  localparam int CLK_NS    = 10;
  localparam int LEGAL_LAT = SET_C + WIN + 2;
  localparam real WIN_NS   = WIN * CLK_NS;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [SEL_W-1:0]  sel_a = '0;
  logic [SEL_W-1:0]  sel_b = '0;
  logic [NUM_RO-1:0] ro_in;
  logic [NUM_RO-1:0] en, en2;
  logic              busy, done, resp, tie, err;
  logic              busy2, done2, resp2, tie2, err2;
  logic [CNT_W-1:0]  ca, cb;
  logic [3:0]        ca2, cb2;

  int half_ns [NUM_RO] = '{default: 20};
  int n_cmp = 0;
  int n_bad = 0;

  always #(CLK_NS/2) clk = ~clk;

  ro_puf_controller #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W),
                      .SETTLE_CYCLES(SET_C), .WINDOW(WIN)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Sel_A(sel_a), .Sel_B(sel_b),
    .RO_in(ro_in), .RO_enable(en), .Busy(busy), .Done(done), .Response(resp),
    .Tie(tie), .Error(err), .Count_A(ca), .Count_B(cb));

  ro_puf_controller #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(4),
                      .SETTLE_CYCLES(SET_C), .WINDOW(WIN)) dut_sat (
    .Clk(clk), .Reset(rst), .Start(start), .Sel_A(sel_a), .Sel_B(sel_b),
    .RO_in(ro_in), .RO_enable(en2), .Busy(busy2), .Done(done2), .Response(resp2),
    .Tie(tie2), .Error(err2), .Count_A(ca2), .Count_B(cb2));

  // Each ring toggles on an even-ns grid (never on a rising clock edge) while enabled.
  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    logic rb = 1'b0;
    initial forever begin
      #(half_ns[g]);
      rb = en[g] ? ~rb : 1'b0;
    end
    assign ro_in[g] = rb;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_near(input string name, input logic [63:0] got, input real exp);
    real d;
    n_cmp++;
    d = real'(got) - exp;
    if ($isunknown(got) || d > 1.0 || d < -1.0) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0.2f +/-1", name, got, exp);
    end
  endtask

  task automatic run(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                     output int lat, output logic [NUM_RO-1:0] en_seen);
    @(negedge clk);
    sel_a = a;
    sel_b = b;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    lat     = 1;
    en_seen = en;
    while (done !== 1'b1 && lat < 4 * LEGAL_LAT) begin
      @(negedge clk);
      lat++;
      en_seen |= en;
    end
    chk("done_seen", done, 1'b1);
  endtask

  typedef struct {
    logic [SEL_W-1:0]  a, b;
    int                ha, hb;
    logic              err;
    int                lat;
    logic [NUM_RO-1:0] en;
    int                ca, cb;
    logic              resp, tie;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int                lat;
    int                n_done;
    logic [NUM_RO-1:0] es, exp_en;
    logic [SEL_W-1:0]  a, b;
    int                ha, hb;
    bit                illegal;
    real               ea, eb;

    tbl[0] = '{5'd3,  5'd7,  20, 30, 1'b0, LEGAL_LAT, 16'h0088, 60, 40, 1'b1, 1'b0};
    tbl[1] = '{5'd7,  5'd3,  30, 20, 1'b0, LEGAL_LAT, 16'h0088, 40, 60, 1'b0, 1'b0};
    tbl[2] = '{5'd5,  5'd5,  20, 20, 1'b1, 1,         16'h0000, 0,  0,  1'b0, 1'b0};
    tbl[3] = '{5'd16, 5'd2,  20, 20, 1'b1, 1,         16'h0000, 0,  0,  1'b0, 1'b0};
    tbl[4] = '{5'd2,  5'd31, 20, 20, 1'b1, 1,         16'h0000, 0,  0,  1'b0, 1'b0};
    tbl[5] = '{5'd0,  5'd15, 24, 50, 1'b0, LEGAL_LAT, 16'h8001, 50, 24, 1'b1, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk("rst_en", en, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_resp", resp, 1'b0);
    chk("rst_tie", tie, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ca", ca, '0);
    chk("rst_cb", cb, '0);
    chk("rst_sat_all", {en2, busy2, done2, resp2, tie2, err2, ca2, cb2}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].a < NUM_RO) half_ns[tbl[i].a] = tbl[i].ha;
      if (tbl[i].b < NUM_RO) half_ns[tbl[i].b] = tbl[i].hb;
      run(tbl[i].a, tbl[i].b, lat, es);
      chk($sformatf("row%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("row%0d_en", i), es, tbl[i].en);
      chk($sformatf("row%0d_err", i), err, tbl[i].err);
      chk_near($sformatf("row%0d_ca", i), ca, real'(tbl[i].ca));
      chk_near($sformatf("row%0d_cb", i), cb, real'(tbl[i].cb));
      chk($sformatf("row%0d_resp", i), resp, tbl[i].resp);
      chk($sformatf("row%0d_tie", i), tie, tbl[i].tie);
    end

    // Saturation and tie on the 4-bit counter instance; results must hold afterwards.
    half_ns[3] = 20;
    half_ns[7] = 20;
    run(5'd3, 5'd7, lat, es);
    chk("sat_ca", ca2, 4'd15);
    chk("sat_cb", cb2, 4'd15);
    chk("sat_tie", tie2, 1'b1);
    chk("sat_resp", resp2, 1'b0);
    chk("sat_err", err2, 1'b0);
    repeat (5) @(negedge clk);
    chk("sat_hold", {tie2, ca2, cb2, busy2}, {1'b1, 4'd15, 4'd15, 1'b0});

    for (int k = 0; k < 30; k++) begin
      a = SEL_W'($urandom_range(0, NUM_RO - 1));
      b = SEL_W'($urandom_range(0, NUM_RO - 1));
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       a = SEL_W'($urandom_range(NUM_RO, 31));
        default: if (a == b) b = SEL_W'((int'(a) + 1) % NUM_RO);
      endcase
      illegal = (a == b) || (a >= NUM_RO) || (b >= NUM_RO);
      ha = 2 * $urandom_range(10, 30);
      hb = 2 * $urandom_range(10, 30);
      exp_en = '0;
      if (!illegal) begin
        half_ns[a] = ha;
        half_ns[b] = hb;
        exp_en[a[3:0]] = 1'b1;
        exp_en[b[3:0]] = 1'b1;
      end
      run(a, b, lat, es);
      chk($sformatf("rnd%0d_lat", k), lat, illegal ? 1 : LEGAL_LAT);
      chk($sformatf("rnd%0d_en", k), es, exp_en);
      chk($sformatf("rnd%0d_err", k), err, illegal);
      if (illegal) begin
        chk($sformatf("rnd%0d_res", k), {resp, tie, ca, cb}, '0);
      end else begin
        ea = WIN_NS / (2.0 * ha);
        eb = WIN_NS / (2.0 * hb);
        chk_near($sformatf("rnd%0d_ca", k), ca, ea);
        chk_near($sformatf("rnd%0d_cb", k), cb, eb);
        if (ea - eb > 2.5 || eb - ea > 2.5) begin
          chk($sformatf("rnd%0d_resp", k), resp, ea > eb);
          chk($sformatf("rnd%0d_tie", k), tie, 1'b0);
        end
      end
    end

    // Reset asserted between clock edges, 100 cycles into the counting window.
    half_ns[3] = 20;
    half_ns[7] = 30;
    @(negedge clk);
    sel_a = 5'd3;
    sel_b = 5'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SET_C + 100) @(negedge clk);
    chk("prerst_busy", busy, 1'b1);
    chk("prerst_en", en, 16'h0088);
    #2 rst = 1'b1;
    #1;
    chk("midrst_en", en, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_counts", {ca, cb}, '0);
    @(negedge clk);
    rst = 1'b0;
    run(5'd3, 5'd7, lat, es);
    chk("postrst_lat", lat, LEGAL_LAT);
    chk_near("postrst_ca", ca, 60.0);
    chk_near("postrst_cb", cb, 40.0);

    // Start pulses with a different pair during SETTLE and COUNT are ignored.
    @(negedge clk);
    sel_a = 5'd3;
    sel_b = 5'd7;
    start = 1'b1;
    @(negedge clk);
    n_done = 0;
    es = en;
    for (int c = 1; c < LEGAL_LAT + 30; c++) begin
      if (c == 3 || c == 60 || c == 200) begin
        sel_a = 5'd5;
        sel_b = 5'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) n_done++;
      es |= en;
    end
    chk("busy_start_dones", n_done, 1);
    chk("busy_start_en", es, 16'h0088);
    chk_near("busy_start_ca", ca, 60.0);
    chk_near("busy_start_cb", cb, 40.0);

    // Start held high on an illegal pair restarts right after each DONE.
    @(negedge clk);
    sel_a = 5'd5;
    sel_b = 5'd5;
    start = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    chk("held_start_dones", n_done, 3);
    chk("held_start_err", err, 1'b1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/ro_puf_controller.md
Name: ro_puf_controller

Overview:
Measurement sequencer for the ring-oscillator PUF array. On Start it takes the challenge (an RO pair Sel_A/Sel_B) and enables only those two rings. After a settle period it counts rising edges of each ring over a fixed clock window. It then compares the counts and returns one response bit, with both counts exposed for characterisation. It sits between the challenge source and the bank of ring_osc instances: it drives their Enable inputs and samples their RO_out outputs.

Parameters:
NUM_RO, 16, number of ring oscillators in the bank.
SEL_W, 4, width of each RO select index.
CNT_W, 16, width of each edge counter; counters saturate at 2^CNT_W-1.
SETTLE_CYCLES, 8, clock cycles rings run before counting starts (must be >=1).
WINDOW, 1024, clock cycles of the counting window (must be >=1).

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request a measurement; sampled only in IDLE.
Sel_A  input  SEL_W  index of ring A; captured when Start is accepted.
Sel_B  input  SEL_W  index of ring B; captured when Start is accepted.
RO_in  input  NUM_RO  RO_out of each ring; asynchronous to Clk.
RO_enable  output  NUM_RO  Enable to each ring; one-hot pair during a run.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse when results are valid.
Response  output  1  1 when Count_A > Count_B, else 0.
Tie  output  1  1 when Count_A == Count_B on a valid run.
Error  output  1  illegal challenge on the last run.
Count_A  output  CNT_W  edges counted on ring A.
Count_B  output  CNT_W  edges counted on ring B.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0, including RO_enable, Count_A and Count_B.
  - Synchronizer and edge-detect flops clear.
  - RO_enable drops immediately, so a measurement interrupted by reset leaves no ring running.
- FSM states and transitions:
  - IDLE: on Start=1, capture Sel_A/Sel_B into registers.
    - Challenge illegal (Sel_A==Sel_B, or either index >= NUM_RO) -> DONE with Error=1.
    - Otherwise -> SETTLE with Error=0.
    - On acceptance, clear Count_A, Count_B, Response and Tie.
  - SETTLE: RO_enable has bits for the captured A and B set, all others 0. Lasts exactly SETTLE_CYCLES cycles, then -> COUNT.
  - COUNT: RO_enable as in SETTLE; counters active. Lasts exactly WINDOW cycles, then -> COMPARE.
  - COMPARE: RO_enable all 0. Response <= (Count_A > Count_B); Tie <= (Count_A == Count_B). Lasts 1 cycle, then -> DONE.
  - DONE: Done=1 for exactly one cycle, then -> IDLE.
- Latency for a legal run: Start sampled at edge t, Done high during cycle t+SETTLE_CYCLES+WINDOW+2. An illegal run raises Done at cycle t+1.
- Edge capture:
  - The registered select muxes RO_in into two channels. Each channel passes through a 2-flop synchronizer plus a third flop for edge detection.
  - A rising edge is sync2 & ~sync3. It increments the counter only while state is COUNT.
  - Edges arriving during SETTLE are ignored.
  - RO frequency must be below Clk/2; faster rings alias, and this is a documented limitation, not checked.
- Counters saturate at all-ones; no wrap.
- Response, Tie, Error, Count_A and Count_B hold their values after DONE until the next accepted Start or Reset.
- Start while Busy=1 is ignored; there is no queuing.
- Start held high continuously starts a new run on the cycle after DONE returns to IDLE.
- Sel_A/Sel_B changes after acceptance have no effect on the current run.

Test Plan:
1. Legal run, Response=1: Clk 10 ns, SETTLE_CYCLES=8, WINDOW=240. Ring 3 modelled at 40 ns period, ring 7 at 60 ns. Start with Sel_A=3, Sel_B=7 -> RO_enable=16'h0088 during SETTLE/COUNT. Done at cycle t+250. Count_A=60±1, Count_B=40±1, Response=1, Tie=0, Error=0.
2. Swapped pair: same setup with Sel_A=7, Sel_B=3 -> Response=0, counts swapped, Tie=0.
3. Illegal challenge:
   - Sel_A=Sel_B=5 -> Done at t+1, Error=1, RO_enable never nonzero, counts 0.
   - Sel_A=16 with NUM_RO=16 -> same result.
4. Saturation and tie: CNT_W=4, both rings at 40 ns period -> Count_A=Count_B=15, Tie=1, Response=0.
5. Reset mid-COUNT: assert Reset 100 cycles into COUNT -> RO_enable=0 and Busy=0 without waiting for a clock edge, counts 0. A new Start then completes normally.
6. Start pulses during SETTLE and COUNT are ignored: exactly one Done per accepted Start, and the captured selects are unchanged.
